// File: rtl/dac_frame_serializer.sv
// ============================================================================
//  Module   : dac_frame_serializer
//  Brief    : Stereo DAC serializer. Accepts one {left,right} word per frame
//             over valid/ready into a 1-entry buffer and shifts it MSB-first
//             onto DACDAT_SER on the BCLK falling edge, aligned to the
//             codec-driven DACLRCK (I2S or left-justified). Reports lock
//             and underrun status.
//  Option   : define DAC_SER_UNDERRUN_CNT_EN to add the saturating 16-bit
//             UNDERRUN_CNT output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dac_frame_serializer #(
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32,
    parameter int MODE     = 1,
    parameter bit LEFT_LVL = 1'b0
) (
    input  logic                  BCLK,
    input  logic                  RST_N,
    input  logic                  DACLRCK,
    input  logic [2*SAMPLE_W-1:0] DATA_PAR,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    output logic                  DACDAT_SER,
    output logic                  LOCKED,
    output logic                  UNDERRUN
`ifdef DAC_SER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           UNDERRUN_CNT
`endif
);

    // Bit counter must hold the lock-loss threshold SLOT_W + 3.
    localparam int               c_bw    = $clog2(SLOT_W + 4);
    localparam logic [c_bw-1:0]  c_b_max = c_bw'(SLOT_W + 3);
    localparam logic [c_bw-1:0]  c_b_lo  = c_bw'(MODE);
    localparam logic [c_bw-1:0]  c_sw    = c_bw'(SAMPLE_W);
    localparam logic [c_bw-1:0]  c_one   = c_bw'(1);

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    lrck_q;
    logic [2*SAMPLE_W-1:0]   buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic [2*SAMPLE_W-1:0]   frame_q, frame_d;
    logic [SAMPLE_W-1:0]     sh_q, sh_d;
    logic [c_bw-1:0]         b_q, b_d;
    logic                    dat_q, dat_d;
    logic                    und_q, und_d;

    logic                    w_slot_edge;
    logic                    w_frame_start;
    logic                    w_accept;
    logic [SAMPLE_W-1:0]     w_src;
    logic [c_bw-1:0]         w_pos;

    assign w_slot_edge   = (DACLRCK != lrck_q);
    assign w_frame_start = w_slot_edge && (DACLRCK == LEFT_LVL);
    assign w_accept      = DATA_VALID && !buf_full_q;

    assign DATA_READY = !buf_full_q;
    assign DACDAT_SER = dat_q;
    assign LOCKED     = (state_q == ST_RUN);
    assign UNDERRUN   = und_q;

    // Next-state: handshake, frame load, slot alignment, bit shifting, lock loss.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        frame_d    = frame_q;
        sh_d       = sh_q;
        b_d        = b_q;
        dat_d      = 1'b0;
        und_d      = 1'b0;
        w_src      = sh_q;
        w_pos      = '0;

        // A word arriving while the buffer is full is ignored; a word on a
        // frame-start cycle with an empty buffer is kept for the next frame.
        if (w_accept) begin
            buf_d      = DATA_PAR;
            buf_full_d = 1'b1;
        end

        // A frame start locks (or keeps) the serializer and loads a new word.
        if (w_frame_start) begin
            state_d = ST_RUN;
            if (buf_full_q) begin
                frame_d    = buf_q;
                buf_full_d = 1'b0;
            end else begin
                frame_d = '0;
                und_d   = 1'b1;
            end
        end

        if (state_d == ST_RUN) begin
            // Any slot edge restarts the slot, dropping unsent bits of a short slot.
            if (w_slot_edge) begin
                b_d   = '0;
                w_src = (DACLRCK == LEFT_LVL) ? frame_d[2*SAMPLE_W-1:SAMPLE_W]
                                              : frame_d[SAMPLE_W-1:0];
            end else if (b_q != c_b_max) begin
                b_d = b_q + c_one;
            end

            // Position wraps to a large value before the first data bit in I2S.
            w_pos = b_d - c_b_lo;

            if (!w_slot_edge && (b_d == c_b_max)) begin
                state_d = ST_SYNC;
            end else if (w_pos < c_sw) begin
                dat_d = w_src[SAMPLE_W-1];
                sh_d  = {w_src[SAMPLE_W-2:0], 1'b0};
            end else begin
                sh_d = w_src;
            end
        end
    end

    // State registers, updated on the BCLK falling edge.
    always_ff @(negedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_SYNC;
            lrck_q     <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            frame_q    <= '0;
            sh_q       <= '0;
            b_q        <= '0;
            dat_q      <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lrck_q     <= DACLRCK;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            frame_q    <= frame_d;
            sh_q       <= sh_d;
            b_q        <= b_d;
            dat_q      <= dat_d;
            und_q      <= und_d;
        end
    end

`ifdef DAC_SER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    assign UNDERRUN_CNT = ucnt_q;

    // Saturating count of underrun pulses, cleared only by reset.
    always_ff @(negedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            ucnt_q <= '0;
        end else if (und_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
